// File: rtl/slice_pkg.sv
// Shared types and width helpers for the slice_stream burst extractor.
// Ports: none (package only).
package slice_pkg;

    typedef enum logic {
        DIR_PLUS  = 1'b0,
        DIR_MINUS = 1'b1
    } dir_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Signed cursor width: large enough that stepping MAX_CNT times by
    // STRIDE in either direction from any base never wraps.
    function automatic int cursor_w(int data_w, int max_cnt, int stride);
        return $clog2(data_w) + $clog2(max_cnt * stride + 1) + 2;
    endfunction

    function automatic int count_w(int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

    function automatic int idx_w(int max_cnt);
        return (max_cnt > 1) ? $clog2(max_cnt) : 1;
    endfunction

    localparam int DEF_CURSOR_W = cursor_w(32, 4, 8);
    localparam int DEF_COUNT_W  = count_w(4);

endpackage

// File: rtl/slice_stream_if.sv
// Request and slice-burst handshake bundle for slice_stream.
// Ports: in_* request channel (valid/ready), out_* slice channel (valid/ready).
interface slice_stream_if #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8,
    parameter int MAX_CNT = 4
);
    import slice_pkg::*;

    localparam int BASE_W = $clog2(DATA_W);
    localparam int CNT_W  = count_w(MAX_CNT);
    localparam int IDX_W  = idx_w(MAX_CNT);

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [BASE_W-1:0]  in_base;
    logic               in_dir;
    logic [CNT_W-1:0]   in_count;

    logic               out_valid;
    logic               out_ready;
    logic [SLICE_W-1:0] out_slice;
    logic               out_oor;
    logic               out_last;
    logic [IDX_W-1:0]   out_idx;

    modport master (
        output in_valid, in_data, in_base, in_dir, in_count, out_ready,
        input  in_ready, out_valid, out_slice, out_oor, out_last, out_idx
    );

    modport slave (
        input  in_valid, in_data, in_base, in_dir, in_count, out_ready,
        output in_ready, out_valid, out_slice, out_oor, out_last, out_idx
    );

endinterface

// File: rtl/slice_window.sv
// Combinational zero-filling part-select around a signed cursor.
// Ports: data, cursor (signed), dir in; slice, oor (any bit out of range) out.
module slice_window #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8,
    parameter int CUR_W   = 13
) (
    input  logic [DATA_W-1:0]       data,
    input  logic signed [CUR_W-1:0] cursor,
    input  logic                    dir,
    output logic [SLICE_W-1:0]      slice,
    output logic                    oor
);
    localparam int AW = $clog2(DATA_W);
    localparam logic signed [CUR_W:0] LIMIT = (CUR_W + 1)'(DATA_W);
    localparam logic signed [CUR_W:0] SPAN  = (CUR_W + 1)'(SLICE_W - 1);

    logic signed [CUR_W:0] low;
    logic signed [CUR_W:0] pos;

    always_comb begin
        low   = {cursor[CUR_W-1], cursor};
        pos   = '0;
        slice = '0;
        oor   = 1'b0;
        // Minus mode selects the window ending at the cursor.
        if (dir) begin
            low = low - SPAN;
        end
        for (int i = 0; i < SLICE_W; i++) begin
            pos = low + (CUR_W + 1)'(i);
            if (pos[CUR_W] || pos >= LIMIT) begin
                oor = 1'b1;
            end else begin
                slice[i] = data[pos[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/slice_stream.sv
// Burst slice extractor: one request in, up to MAX_CNT strided slices out.
// Ports: clk, rst (async active-high), bus (slice_stream_if.slave).
module slice_stream
    import slice_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8,
    parameter int STRIDE  = 8,
    parameter int MAX_CNT = 4
) (
    input  logic          clk,
    input  logic          rst,
    slice_stream_if.slave bus
);
    localparam int BASE_W = $clog2(DATA_W);
    localparam int CUR_W  = cursor_w(DATA_W, MAX_CNT, STRIDE);
    localparam int CNT_W  = count_w(MAX_CNT);
    localparam int IDX_W  = idx_w(MAX_CNT);

    localparam logic signed [CUR_W-1:0] STEP = CUR_W'(STRIDE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    state_e                   state;
    logic [DATA_W-1:0]        data_q;
    dir_e                     dir_q;
    logic signed [CUR_W-1:0]  cursor_q;
    logic [CNT_W-1:0]         remaining_q;

    logic                     rdy_q;
    logic                     valid_q;
    logic [SLICE_W-1:0]       slice_q;
    logic                     oor_q;
    logic                     last_q;
    logic [IDX_W-1:0]         idx_q;

    logic [CNT_W-1:0]         norm_count;
    logic signed [CUR_W-1:0]  base_ext;
    logic signed [CUR_W-1:0]  cursor_step;
    logic [DATA_W-1:0]        win_data;
    logic signed [CUR_W-1:0]  win_cursor;
    logic                     win_dir;
    logic [SLICE_W-1:0]       win_slice;
    logic                     win_oor;

    always_comb begin
        norm_count = bus.in_count;
        if (bus.in_count == '0) begin
            norm_count = CNT_ONE;
        end else if (bus.in_count > CNT_MAX) begin
            norm_count = CNT_MAX;
        end
    end

    assign base_ext = {{(CUR_W - BASE_W){1'b0}}, bus.in_base};
    assign cursor_step = (dir_q == DIR_MINUS) ? cursor_q - STEP
                                              : cursor_q + STEP;

    // In IDLE the window sees the live request so beat 0 is registered
    // on the accept edge; in RUN it sees the captured word at the next
    // cursor position.
    always_comb begin
        win_data   = data_q;
        win_cursor = cursor_step;
        win_dir    = dir_q;
        if (state == IDLE) begin
            win_data   = bus.in_data;
            win_cursor = base_ext;
            win_dir    = bus.in_dir;
        end
    end

    slice_window #(
        .DATA_W  (DATA_W),
        .SLICE_W (SLICE_W),
        .CUR_W   (CUR_W)
    ) u_window (
        .data   (win_data),
        .cursor (win_cursor),
        .dir    (win_dir),
        .slice  (win_slice),
        .oor    (win_oor)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            dir_q       <= DIR_PLUS;
            cursor_q    <= '0;
            remaining_q <= '0;
            rdy_q       <= 1'b1;
            valid_q     <= 1'b0;
            slice_q     <= '0;
            oor_q       <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && rdy_q) begin
                        state       <= RUN;
                        rdy_q       <= 1'b0;
                        data_q      <= bus.in_data;
                        dir_q       <= dir_e'(bus.in_dir);
                        cursor_q    <= base_ext;
                        remaining_q <= norm_count;
                        valid_q     <= 1'b1;
                        slice_q     <= win_slice;
                        oor_q       <= win_oor;
                        last_q      <= (norm_count == CNT_ONE);
                        idx_q       <= '0;
                    end
                end
                RUN: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            state   <= IDLE;
                            rdy_q   <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            cursor_q    <= cursor_step;
                            remaining_q <= remaining_q - CNT_ONE;
                            idx_q       <= idx_q + IDX_W'(1);
                            slice_q     <= win_slice;
                            oor_q       <= win_oor;
                            last_q      <= (remaining_q == CNT_TWO);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_slice = slice_q;
    assign bus.out_oor   = oor_q;
    assign bus.out_last  = last_q;
    assign bus.out_idx   = idx_q;

endmodule

// File: doc/slice_stream.md
# slice_stream

Streaming, parametrised successor to the fixed indexed part-select logic. It accepts a data word with a runtime base offset, a direction (`+:` or `-:`) and a beat count. It then emits a burst of SLICE_W-bit slices over a valid/ready interface, stepping the base by STRIDE each beat. Out-of-range bits are zero-filled and flagged. It sits between a register/packet source and downstream field consumers that need sequential field extraction under backpressure.

## Interface
- DATA_W, 32, width of the input word
- SLICE_W, 8, width of each extracted slice
- STRIDE, 8, base step between consecutive beats
- MAX_CNT, 4, maximum slices per request
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_data  in  DATA_W  source word
- in_base  in  $clog2(DATA_W)  starting bit offset
- in_dir  in  1  0 = plus (`base+:SLICE_W`), 1 = minus (`base-:SLICE_W`)
- in_count  in  $clog2(MAX_CNT+1)  number of slices; 0 is treated as 1, values above MAX_CNT are clamped to MAX_CNT
- out_valid  out  1  slice valid
- out_ready  in  1  consumer ready
- out_slice  out  SLICE_W  extracted slice
- out_oor  out  1  at least one slice bit index was outside [0, DATA_W-1]
- out_last  out  1  final beat of the burst
- out_idx  out  $clog2(MAX_CNT)  beat index within the burst, starting at 0

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - RUN: in_ready=0.
- IDLE -> RUN on an input handshake. On that edge the block captures in_data, in_dir, cursor=in_base and remaining=count (normalised as above), and loads the output register with beat 0.
- RUN: out_valid=1. On out_valid && out_ready:
  - if this is the last beat, go to IDLE and drop out_valid;
  - otherwise the cursor moves by STRIDE (plus: +STRIDE, minus: -STRIDE), remaining decrements, out_idx increments, and the output register loads the next slice.
- Cursor is signed and wide enough to never wrap: $clog2(DATA_W) + $clog2(MAX_CNT*STRIDE+1) + 2 bits.
- Plus mode: out_slice[i] = data[cursor+i].
- Minus mode: out_slice[i] = data[cursor-SLICE_W+1+i].
- Any index below 0 or at/above DATA_W yields bit 0 and sets out_oor for that beat.
- out_slice, out_oor, out_last and out_idx are held stable while out_valid && !out_ready.
- rst asserted at any time, including mid-burst, aborts the burst immediately; there is no partial resume.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1
  - out_valid = 0, out_slice = 0, out_oor = 0, out_last = 0, out_idx = 0
  - internal data, cursor and remaining = 0
- Latency: input handshake in cycle N -> first out_valid in cycle N+1.
- Throughput: 1 slice/cycle with out_ready held high.
- A burst of n beats occupies n cycles.
- in_ready returns high the cycle after the last-beat handshake. This leaves one bubble between bursts; there is no same-cycle re-accept.
- in_ready is a registered-state decode with no combinational path from out_ready.
- Input signals are ignored outside the handshake cycle; changing them in RUN has no effect.

## Structure
- Package slice_pkg holds:
  - dir_e: DIR_PLUS = 0, DIR_MINUS = 1
  - state_e: IDLE, RUN
  - width helper constants: cursor width, count width
- Sub-module slice_window: a combinational zero-filling part-select. Inputs: data, signed cursor, dir. Outputs: slice, oor. Parametrised by DATA_W and SLICE_W and instantiated once.
- The top level holds the FSM, the capture registers and the output register.

## Test plan
All scenarios use DATA_W=32, SLICE_W=8, STRIDE=8, MAX_CNT=4.
- Single plus: data=0xA5C30F96, base=4, dir=0, count=1 -> one beat, out_slice=0xF9, oor=0, last=1, idx=0, valid in cycle N+1.
- Single minus, low edge: same data, base=4, dir=1, count=1 -> out_slice=0xB0, oor=1, last=1.
- Plus burst: data=0x44332211, base=0, dir=0, count=4, out_ready=1 -> slices 0x11, 0x22, 0x33, 0x44 in consecutive cycles, idx 0..3, oor=0, last only on the 4th, in_ready=1 on the following cycle.
- Backpressure: same burst with out_ready low for 3 cycles after beat 1 -> 0x22 held stable with idx=1 across the stall, no beat skipped or duplicated, total 4 handshakes.
- High edge plus count clamping: data=0xF0000000, base=28, dir=0, count=2 -> beat 0 out_slice=0x0F with oor=1, beat 1 out_slice=0x00 with oor=1 and last=1. Then count=7 -> exactly 4 beats.
- Reset mid-burst: assert rst after the beat-1 handshake of a count=4 burst -> out_valid=0 asynchronously and all outputs at reset values. After release, in_ready=1, and a new request (base=8, count=1, data=0x44332211) yields 0x22.
